bunch_seq_ctrl: RTL



---
 rtl/bunch_seq_pkg.sv | 26 ++
 rtl/bunch_seq_cfg_regs.sv | 100 ++++++++++
 rtl/bunch_seq_ctrl.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/bunch_seq_pkg.sv
// Shared state encoding and host register map for the bunch strobe sequencer.
package bunch_seq_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ARMED   = 3'd1,
      ST_DELAY   = 3'd2,
      ST_STORE   = 3'd3,
      ST_HOLDOFF = 3'd4
   } seqState_e;

   localparam logic [2:0] ADDR_B1    = 3'd0;
   localparam logic [2:0] ADDR_B2    = 3'd1;
   localparam logic [2:0] ADDR_BUNCH = 3'd2;
   localparam logic [2:0] ADDR_SP    = 3'd3;
   localparam logic [2:0] ADDR_DELAY = 3'd4;
   localparam logic [2:0] ADDR_LEN   = 3'd5;
   localparam logic [2:0] ADDR_HOLD  = 3'd6;
   localparam logic [2:0] ADDR_CTRL  = 3'd7;

   localparam int NB_HI = 5;
   localparam int NB_LO = 4;
   localparam int NS_HI = 3;
   localparam int NS_LO = 0;

endpackage

// File: rtl/bunch_seq_cfg_regs.sv
// Shadow/active strobe configuration plus the immediately-acting timing registers.
module bunch_seq_cfg_regs
   import bunch_seq_pkg::*;
#(
   parameter logic [7:0] B1_DEF   = 8'd10,
   parameter logic [7:0] B2_DEF   = 8'd20,
   parameter logic [1:0] NB_DEF   = 2'd2,
   parameter logic [3:0] NS_DEF   = 4'd1,
   parameter logic [7:0] SP_DEF   = 8'd100,
   parameter logic [7:0] LEN_DEF  = 8'd200,
   parameter logic [7:0] HOLD_DEF = 8'd16
)
(
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       cfg_wr_i,
   input  logic [2:0] cfg_addr_i,
   input  logic [7:0] cfg_data_i,
   input  logic       latch_i,
   output logic [7:0] b1_strobe_o,
   output logic [7:0] b2_strobe_o,
   output logic [1:0] no_bunches_o,
   output logic [3:0] no_samples_o,
   output logic [7:0] sample_spacing_o,
   output logic [7:0] trig_delay_o,
   output logic [7:0] store_len_o,
   output logic [7:0] holdoff_o,
   output logic       auto_rearm_o,
   output logic       cfg_pending_o
);

   logic [7:0] b1Shadow_q, b2Shadow_q, spShadow_q;
   logic [1:0] nbShadow_q;
   logic [3:0] nsShadow_q;
   logic [7:0] b1Active_q, b2Active_q, spActive_q;
   logic [1:0] nbActive_q;
   logic [3:0] nsActive_q;
   logic [7:0] trigDelay_q, storeLen_q, holdoff_q;
   logic       autoRearm_q, cfgPending_q;

   // Latch copies the pre-write shadow, so a write in the latch cycle stays pending.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         b1Shadow_q   <= B1_DEF;
         b2Shadow_q   <= B2_DEF;
         nbShadow_q   <= NB_DEF;
         nsShadow_q   <= NS_DEF;
         spShadow_q   <= SP_DEF;
         b1Active_q   <= B1_DEF;
         b2Active_q   <= B2_DEF;
         nbActive_q   <= NB_DEF;
         nsActive_q   <= NS_DEF;
         spActive_q   <= SP_DEF;
         trigDelay_q  <= 8'd0;
         storeLen_q   <= LEN_DEF;
         holdoff_q    <= HOLD_DEF;
         autoRearm_q  <= 1'b0;
         cfgPending_q <= 1'b0;
      end else begin
         if (cfg_wr_i) begin
            case (cfg_addr_i)
               ADDR_B1:    b1Shadow_q <= cfg_data_i;
               ADDR_B2:    b2Shadow_q <= cfg_data_i;
               ADDR_BUNCH: begin
                  nbShadow_q <= cfg_data_i[NB_HI:NB_LO];
                  nsShadow_q <= cfg_data_i[NS_HI:NS_LO];
               end
               ADDR_SP:    spShadow_q  <= cfg_data_i;
               ADDR_DELAY: trigDelay_q <= cfg_data_i;
               ADDR_LEN:   storeLen_q  <= cfg_data_i;
               ADDR_HOLD:  holdoff_q   <= cfg_data_i;
               ADDR_CTRL:  autoRearm_q <= cfg_data_i[0];
            endcase
         end
         if (latch_i) begin
            b1Active_q <= b1Shadow_q;
            b2Active_q <= b2Shadow_q;
            nbActive_q <= nbShadow_q;
            nsActive_q <= nsShadow_q;
            spActive_q <= spShadow_q;
         end
         if (cfg_wr_i && (cfg_addr_i <= ADDR_SP))
            cfgPending_q <= 1'b1;
         else if (latch_i)
            cfgPending_q <= 1'b0;
      end
   end

   assign b1_strobe_o      = b1Active_q;
   assign b2_strobe_o      = b2Active_q;
   assign no_bunches_o     = nbActive_q;
   assign no_samples_o     = nsActive_q;
   assign sample_spacing_o = spActive_q;
   assign trig_delay_o     = trigDelay_q;
   assign store_len_o      = storeLen_q;
   assign holdoff_o        = holdoff_q;
   assign auto_rearm_o     = autoRearm_q;
   assign cfg_pending_o    = cfgPending_q;

endmodule

// File: rtl/bunch_seq_ctrl.sv
// Per-machine-pulse sequencer: arm, wait for trigger, delay, store window, holdoff.
module bunch_seq_ctrl
   import bunch_seq_pkg::*;
#(
   parameter logic [7:0] B1_DEF   = 8'd10,
   parameter logic [7:0] B2_DEF   = 8'd20,
   parameter logic [1:0] NB_DEF   = 2'd2,
   parameter logic [3:0] NS_DEF   = 4'd1,
   parameter logic [7:0] SP_DEF   = 8'd100,
   parameter logic [7:0] LEN_DEF  = 8'd200,
   parameter logic [7:0] HOLD_DEF = 8'd16
)
(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        arm_i,
   input  logic        abort_i,
   input  logic        trig_i,
   input  logic        cfg_wr_i,
   input  logic [2:0]  cfg_addr_i,
   input  logic [7:0]  cfg_data_i,
   output logic        store_strb_o,
   output logic [7:0]  b1_strobe_o,
   output logic [7:0]  b2_strobe_o,
   output logic [1:0]  no_bunches_o,
   output logic [3:0]  no_samples_o,
   output logic [7:0]  sample_spacing_o,
   output logic        busy_o,
   output logic        armed_o,
   output logic        cfg_pending_o,
   output logic        trig_overrun_o,
   output logic [15:0] pulse_count_o
);

   seqState_e   state_q;
   logic [7:0]  cnt_q;
   logic        storeStrb_q, busy_q, armed_q, trigOverrun_q;
   logic [15:0] pulseCount_q;
   logic [7:0]  trigDelay, storeLen, holdoff, holdoffLoad;
   logic        autoRearm, latchCfg;

   assign latchCfg    = (state_q == ST_ARMED) && trig_i && !abort_i;
   assign holdoffLoad = (holdoff == 8'd0) ? 8'd0 : holdoff - 8'd1;

   bunch_seq_cfg_regs #(
      .B1_DEF(B1_DEF), .B2_DEF(B2_DEF), .NB_DEF(NB_DEF), .NS_DEF(NS_DEF),
      .SP_DEF(SP_DEF), .LEN_DEF(LEN_DEF), .HOLD_DEF(HOLD_DEF)
   ) cfgRegs (
      .clk_i(clk_i), .rst_i(rst_i),
      .cfg_wr_i(cfg_wr_i), .cfg_addr_i(cfg_addr_i), .cfg_data_i(cfg_data_i),
      .latch_i(latchCfg),
      .b1_strobe_o(b1_strobe_o), .b2_strobe_o(b2_strobe_o),
      .no_bunches_o(no_bunches_o), .no_samples_o(no_samples_o),
      .sample_spacing_o(sample_spacing_o),
      .trig_delay_o(trigDelay), .store_len_o(storeLen), .holdoff_o(holdoff),
      .auto_rearm_o(autoRearm), .cfg_pending_o(cfg_pending_o)
   );

   // Loading storeLen-1 lets a zero length wrap naturally to a 256-cycle window.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q       <= ST_IDLE;
         cnt_q         <= 8'd0;
         storeStrb_q   <= 1'b0;
         busy_q        <= 1'b0;
         armed_q       <= 1'b0;
         trigOverrun_q <= 1'b0;
         pulseCount_q  <= 16'd0;
      end else if (abort_i) begin
         state_q     <= ST_IDLE;
         storeStrb_q <= 1'b0;
         busy_q      <= 1'b0;
         armed_q     <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (arm_i) begin
                  state_q       <= ST_ARMED;
                  armed_q       <= 1'b1;
                  trigOverrun_q <= 1'b0;
               end
            end
            ST_ARMED: begin
               if (trig_i) begin
                  armed_q <= 1'b0;
                  busy_q  <= 1'b1;
                  if (trigDelay == 8'd0) begin
                     state_q      <= ST_STORE;
                     storeStrb_q  <= 1'b1;
                     cnt_q        <= storeLen - 8'd1;
                     pulseCount_q <= pulseCount_q + 16'd1;
                  end else begin
                     state_q <= ST_DELAY;
                     cnt_q   <= trigDelay - 8'd1;
                  end
               end
            end
            ST_DELAY: begin
               if (trig_i) trigOverrun_q <= 1'b1;
               if (cnt_q == 8'd0) begin
                  state_q      <= ST_STORE;
                  storeStrb_q  <= 1'b1;
                  cnt_q        <= storeLen - 8'd1;
                  pulseCount_q <= pulseCount_q + 16'd1;
               end else begin
                  cnt_q <= cnt_q - 8'd1;
               end
            end
            ST_STORE: begin
               if (trig_i) trigOverrun_q <= 1'b1;
               if (cnt_q == 8'd0) begin
                  state_q     <= ST_HOLDOFF;
                  storeStrb_q <= 1'b0;
                  cnt_q       <= holdoffLoad;
               end else begin
                  cnt_q <= cnt_q - 8'd1;
               end
            end
            ST_HOLDOFF: begin
               if (trig_i) trigOverrun_q <= 1'b1;
               if (cnt_q == 8'd0) begin
                  busy_q  <= 1'b0;
                  armed_q <= autoRearm;
                  state_q <= autoRearm ? ST_ARMED : ST_IDLE;
               end else begin
                  cnt_q <= cnt_q - 8'd1;
               end
            end
            default: begin
               state_q     <= ST_IDLE;
               storeStrb_q <= 1'b0;
               busy_q      <= 1'b0;
               armed_q     <= 1'b0;
            end
         endcase
      end
   end

   assign store_strb_o   = storeStrb_q;
   assign busy_o         = busy_q;
   assign armed_o        = armed_q;
   assign trig_overrun_o = trigOverrun_q;
   assign pulse_count_o  = pulseCount_q;

endmodule
